// File: rtl/reg_names_pkg.sv
// Shared register-file naming: widths, register count and ABI register names.
package reg_names;

    localparam int DATA_WIDTH = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_SIZE   = $clog2(REG_COUNT);

    // RISC-V ABI names in architectural index order.
    typedef enum logic [REG_SIZE-1:0] {
        zero, ra, sp, gp, tp, t0, t1, t2,
        s0, s1, a0, a1, a2, a3, a4, a5,
        a6, a7, s2, s3, s4, s5, s6, s7,
        s8, s9, s10, s11, t3, t4, t5, t6
    } regName_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding write, detects
// RAW/WAW hazards for the issuing instruction and counts busy registers.
module reg_scoreboard
    import reg_names::regName_t;
#(
    parameter int REG_COUNT = reg_names::REG_COUNT
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  regName_t                        rs1_addr,
    input  regName_t                        rs2_addr,
    input  logic                            issue_valid,
    input  regName_t                        issue_rd,
    input  logic                            issue_uses_rs1,
    input  logic                            issue_uses_rs2,
    input  logic                            wb_en,
    input  regName_t                        wb_rd,
    input  logic                            flush,
    output logic                            stall,
    output logic [$clog2(REG_COUNT):0]      pending_cnt
);

    localparam int REG_SIZE = $clog2(REG_COUNT);
    localparam logic [REG_SIZE:0] CNT_ONE = 1;

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [REG_SIZE:0]    cnt_q, cnt_d;
    logic [REG_SIZE-1:0]  rs1_idx, rs2_idx, rd_idx, wb_idx;
    logic                 haz_rs1, haz_rs2, haz_waw;
    logic                 set_busy, clr_busy;

    assign rs1_idx = rs1_addr;
    assign rs2_idx = rs2_addr;
    assign rd_idx  = issue_rd;
    assign wb_idx  = wb_rd;

    // Hazard detection, busy-bit next state and counter next state.
    always_comb begin
        // A register being written back this cycle is already resolved.
        haz_rs1 = issue_uses_rs1 && busy_q[rs1_idx] && !(wb_en && wb_idx == rs1_idx);
        haz_rs2 = issue_uses_rs2 && busy_q[rs2_idx] && !(wb_en && wb_idx == rs2_idx);
        haz_waw = (rd_idx != '0) && busy_q[rd_idx] && !(wb_en && wb_idx == rd_idx);

        stall    = rstN && issue_valid && (haz_rs1 || haz_rs2 || haz_waw) && !flush;
        set_busy = issue_valid && !stall && !flush && (rd_idx != '0);
        // Only a clear of a bit that is actually set changes the count.
        clr_busy = wb_en && (wb_idx != '0) && busy_q[wb_idx];

        busy_d = busy_q;
        if (clr_busy) begin
            busy_d[wb_idx] = 1'b0;
        end
        // Applied after the clear so a same-cycle set on the same index wins.
        if (set_busy) begin
            busy_d[rd_idx] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (set_busy && !clr_busy) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!set_busy && clr_busy) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Scoreboard state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with writeback bypass and an attached
// scoreboard that stalls decode on pending-write hazards.
module reg_file_sb
    import reg_names::regName_t;
#(
    parameter int DATA_WIDTH = reg_names::DATA_WIDTH,
    parameter int REG_COUNT  = reg_names::REG_COUNT
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  regName_t                        rs1_addr,
    input  regName_t                        rs2_addr,
    output logic [DATA_WIDTH-1:0]           rs1_data,
    output logic [DATA_WIDTH-1:0]           rs2_data,
    input  logic                            issue_valid,
    input  regName_t                        issue_rd,
    input  logic                            issue_uses_rs1,
    input  logic                            issue_uses_rs2,
    output logic                            stall,
    input  logic                            wb_en,
    input  regName_t                        wb_rd,
    input  logic [DATA_WIDTH-1:0]           wb_data,
    input  logic                            flush,
    output logic [$clog2(REG_COUNT):0]      pending_cnt
);

    localparam int REG_SIZE = $clog2(REG_COUNT);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_SIZE-1:0]   rs1_idx, rs2_idx, wb_idx;

    assign rs1_idx = rs1_addr;
    assign rs2_idx = rs2_addr;
    assign wb_idx  = wb_rd;

    // Combinational reads: x0 reads zero, a same-cycle writeback is forwarded.
    always_comb begin
        rs1_data = regs_q[rs1_idx];
        if (rs1_idx == '0) begin
            rs1_data = '0;
        end else if (wb_en && wb_idx == rs1_idx) begin
            rs1_data = wb_data;
        end

        rs2_data = regs_q[rs2_idx];
        if (rs2_idx == '0) begin
            rs2_data = '0;
        end else if (wb_en && wb_idx == rs2_idx) begin
            rs2_data = wb_data;
        end
    end

    // Register storage; writes to x0 are dropped, flush does not block writes.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && wb_idx != '0) begin
            regs_q[wb_idx] <= wb_data;
        end
    end

    reg_scoreboard #(
        .REG_COUNT(REG_COUNT)
    ) u_scoreboard (
        .clk            (clk),
        .rstN           (rstN),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .stall          (stall),
        .pending_cnt    (pending_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios followed by random traffic,
// all checked against a behavioural array model of registers and busy flags.
module tb_reg_file_sb;
    import reg_names::*;

    logic        clk;
    logic        rstN;
    regName_t    rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid;
    regName_t    issue_rd;
    logic        issue_uses_rs1, issue_uses_rs2;
    logic        stall;
    logic        wb_en;
    regName_t    wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [5:0]  pending_cnt;

    int tests;
    int fails;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_sb dut (
        .clk            (clk),
        .rstN           (rstN),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_uses_rs1 (issue_uses_rs1),
        .issue_uses_rs2 (issue_uses_rs2),
        .stall          (stall),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .pending_cnt    (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic regName_t rnd_reg();
        logic [4:0] v;
        v = 5'($urandom_range(0, 31));
        return regName_t'(v);
    endfunction

    function automatic bit wb_hits(int a);
        return wb_en && (int'(wb_rd) == a);
    endfunction

    function automatic logic [31:0] model_read(int a);
        if (a == 0) return 32'h0;
        if (wb_hits(a)) return wb_data;
        return m_regs[a];
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic idle();
        issue_valid = 1'b0; issue_rd = zero;
        issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
        rs1_addr = zero; rs2_addr = zero;
        wb_en = 1'b0; wb_rd = zero; wb_data = 32'h0;
        flush = 1'b0;
    endtask

    task automatic issue(input regName_t rd, input bit u1, input regName_t r1,
                         input bit u2, input regName_t r2);
        issue_valid = 1'b1; issue_rd = rd;
        issue_uses_rs1 = u1; rs1_addr = r1;
        issue_uses_rs2 = u2; rs2_addr = r2;
    endtask

    task automatic wb(input regName_t rd, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    // Called right after an edge with the inputs for this cycle already set.
    task automatic cycle();
        int r1, r2, rd, wr;
        bit es;
        #3;
        r1 = int'(rs1_addr); r2 = int'(rs2_addr);
        rd = int'(issue_rd); wr = int'(wb_rd);
        es = rstN && issue_valid && !flush &&
             ((issue_uses_rs1 && m_busy[r1] && !wb_hits(r1)) ||
              (issue_uses_rs2 && m_busy[r2] && !wb_hits(r2)) ||
              (rd != 0 && m_busy[rd] && !wb_hits(rd)));
        chk("stall", {63'b0, stall}, {63'b0, es});
        chk("rs1_data", {32'b0, rs1_data}, {32'b0, model_read(r1)});
        chk("rs2_data", {32'b0, rs2_data}, {32'b0, model_read(r2)});
        if (!rstN) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wb_en && wr != 0) begin
                m_regs[wr] = wb_data;
                m_busy[wr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (issue_valid && !es && rd != 0) begin
                m_busy[rd] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("pending_cnt", {58'b0, pending_cnt}, 64'(busy_count()));
    endtask

    task automatic peek_stall(input string tag, input bit exp);
        #2;
        chk(tag, {63'b0, stall}, {63'b0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        idle();
        rstN = 1'b0;
        @(posedge clk);
        #1;

        // Reset, with an issue present to show stall is held low.
        issue(t0, 1'b1, t0, 1'b0, zero);
        cycle();
        idle();
        cycle();
        chk("reset_cnt", {58'b0, pending_cnt}, 64'd0);
        rstN = 1'b1;

        // x0 write is ignored.
        wb(zero, 32'hFFFF_FFFF);
        cycle();
        idle();
        cycle();
        chk("x0_read", {32'b0, rs1_data}, 64'd0);
        chk("x0_cnt", {58'b0, pending_cnt}, 64'd0);

        // Bypass of a0 in the write cycle, then stored value afterwards.
        wb(a0, 32'h1234_5678);
        rs1_addr = a0;
        #2;
        chk("bypass_same", {32'b0, rs1_data}, 64'h1234_5678);
        cycle();
        idle();
        rs1_addr = a0;
        cycle();
        chk("bypass_after", {32'b0, rs1_data}, 64'h1234_5678);

        // RAW on t0: stall until writeback, released in the writeback cycle.
        issue(t0, 1'b0, zero, 1'b0, zero);
        cycle();
        chk("raw_cnt1", {58'b0, pending_cnt}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            idle();
            issue(zero, 1'b1, t0, 1'b0, zero);
            peek_stall("raw_stall", 1'b1);
            cycle();
        end
        wb(t0, 32'hCAFE_0001);
        peek_stall("raw_release", 1'b0);
        cycle();
        chk("raw_cnt0", {58'b0, pending_cnt}, 64'd0);

        // WAW on s2 resolved by a same-cycle writeback; set wins over clear.
        idle();
        issue(s2, 1'b0, zero, 1'b0, zero);
        cycle();
        idle();
        issue(s2, 1'b0, zero, 1'b0, zero);
        wb(s2, 32'h0000_5252);
        peek_stall("waw_stall", 1'b0);
        cycle();
        chk("waw_cnt", {58'b0, pending_cnt}, 64'd1);
        idle();
        issue(zero, 1'b1, s2, 1'b0, zero);
        peek_stall("waw_still_busy", 1'b1);
        cycle();
        idle();
        wb(s2, 32'h0000_5353);
        cycle();

        // Flush with three pending writes and a simultaneous issue.
        idle();
        issue(ra, 1'b0, zero, 1'b0, zero); cycle();
        issue(sp, 1'b0, zero, 1'b0, zero); cycle();
        issue(gp, 1'b0, zero, 1'b0, zero); cycle();
        chk("flush_pre", {58'b0, pending_cnt}, 64'd3);
        issue(tp, 1'b1, ra, 1'b1, sp);
        flush = 1'b1;
        peek_stall("flush_stall", 1'b0);
        cycle();
        chk("flush_cnt", {58'b0, pending_cnt}, 64'd0);
        idle();
        wb(ra, 32'hA5A5_0F0F);
        cycle();
        chk("flush_wb_cnt", {58'b0, pending_cnt}, 64'd0);
        idle();
        issue(zero, 1'b1, ra, 1'b1, tp);
        peek_stall("flush_no_busy", 1'b0);
        cycle();
        chk("flush_wb_data", {32'b0, rs1_data}, 64'hA5A5_0F0F);

        // Reset in the middle of activity.
        idle();
        issue(t1, 1'b0, zero, 1'b0, zero); cycle();
        issue(t2, 1'b0, zero, 1'b0, zero); cycle();
        chk("mid_pre", {58'b0, pending_cnt}, 64'd2);
        rstN = 1'b0;
        issue(t2, 1'b1, t1, 1'b0, zero);
        wb(t1, 32'hDEAD_BEEF);
        peek_stall("mid_rst_stall", 1'b0);
        cycle();
        rstN = 1'b1;
        idle();
        issue(zero, 1'b1, t1, 1'b1, a0);
        peek_stall("mid_post_stall", 1'b0);
        chk("mid_rst_t1", {32'b0, rs1_data}, 64'd0);
        chk("mid_rst_a0", {32'b0, rs2_data}, 64'd0);
        chk("mid_rst_cnt", {58'b0, pending_cnt}, 64'd0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            idle();
            rstN = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 1) == 1) begin
                issue(rnd_reg(), 1'($urandom_range(0, 1)), rnd_reg(),
                      1'($urandom_range(0, 1)), rnd_reg());
            end else begin
                rs1_addr = rnd_reg();
                rs2_addr = rnd_reg();
            end
            if ($urandom_range(0, 2) == 0) wb(rnd_reg(), $urandom);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32: register and data width.
REQ-002 SHALL take parameter REG_COUNT, default 32: number of architectural registers.
REQ-003 SHALL derive REG_SIZE = $clog2(REG_COUNT), default 5: register index width.
REQ-004 SHALL have port clk  in  1  clock; the block uses one clock, and all state updates on its rising edge.
REQ-005 SHALL have port rstN  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports rs1_addr, rs2_addr  in  REG_SIZE  source register indices, typed regName_t.
REQ-007 SHALL have ports rs1_data, rs2_data  out  DATA_WIDTH  source operand values.
REQ-008 SHALL have port issue_valid  in  1  decode presents an instruction this cycle.
REQ-009 SHALL have port issue_rd  in  REG_SIZE  destination index of the issuing instruction; zero means no destination.
REQ-010 SHALL have ports issue_uses_rs1, issue_uses_rs2  in  1  the instruction reads that source.
REQ-011 SHALL have port stall  out  1  the issuing instruction must be held in decode.
REQ-012 SHALL have ports wb_en  in  1, wb_rd  in  REG_SIZE, wb_data  in  DATA_WIDTH  writeback request.
REQ-013 SHALL have port flush  in  1  discards all pending-write tracking.
REQ-014 SHALL have port pending_cnt  out  REG_SIZE+1  count of busy registers.

Function
REQ-015 SHALL read combinationally; a read of index 0 SHALL return 0.
REQ-016 SHALL bypass writes: when wb_en=1, wb_rd=rsX and rsX≠0, rsX_data SHALL equal wb_data in the same cycle.
REQ-017 SHALL write regs[wb_rd] <= wb_data at the clock edge when wb_en=1 and wb_rd≠0; writes to index 0 SHALL be ignored.
REQ-018 SHALL keep a busy bit per register; busy[0] SHALL be constant 0.
REQ-019 SHALL count a source hazard when issue_uses_rsX=1, busy[rsX]=1, and the register is not being written back this cycle.
REQ-020 SHALL count a WAW hazard when issue_rd≠0, busy[issue_rd]=1, and the register is not being written back this cycle.
REQ-021 SHALL drive stall = issue_valid AND (any source hazard OR WAW hazard) AND NOT flush, combinationally.
REQ-022 SHALL set busy[issue_rd] at the edge when issue_valid=1, stall=0, flush=0 and issue_rd≠0.
REQ-023 SHALL clear busy[wb_rd] at the edge when wb_en=1 and wb_rd≠0; when the same register is set and cleared in one cycle, the set SHALL win.
REQ-024 SHALL clear every busy bit when flush=1, with priority over issue; the register write still occurs.
REQ-025 SHALL update pending_cnt as a registered counter: +1 on a busy set, -1 on a clear of a busy bit, and unchanged when both happen or on writeback to a non-busy register.
REQ-026 SHALL drive pending_cnt to 0 on flush; the counter SHALL NOT wrap, since at most REG_COUNT-1 registers can be busy.

Reset
REQ-027 SHALL, when rstN=0 at a clock edge, clear all registers, all busy bits and pending_cnt to 0; stall SHALL be 0 while rstN=0.
REQ-028 SHALL give reset priority over flush, issue and writeback issued in the same cycle.

Structure
REQ-029 SHALL take DATA_WIDTH, REG_COUNT, REG_SIZE and regName_t from shared package reg_names; no local redefinition.
REQ-030 SHALL place busy bits, hazard logic and the counter in sub-module reg_scoreboard; data storage and bypass SHALL stay in reg_file_sb.

Verification
REQ-031 SHALL cover x0: wb_en=1, wb_rd=zero, wb_data=32'hFFFF_FFFF, then read rs1=zero -> rs1_data=0 and pending_cnt=0.
REQ-032 SHALL cover bypass: wb a0 <= 32'h1234_5678 with rs1_addr=a0 in the same cycle -> rs1_data=32'h1234_5678 that cycle and after.
REQ-033 SHALL cover RAW stall: issue rd=t0, then issue with rs1=t0 and uses_rs1=1 -> stall=1 until wb t0; stall=0 in the wb cycle; pending_cnt goes 1 -> 0.
REQ-034 SHALL cover WAW plus same-cycle set/clear: busy s2, issue rd=s2 while wb s2 -> stall=0, busy[s2] stays 1, pending_cnt stays 1.
REQ-035 SHALL cover flush: issue ra, sp, gp (pending_cnt=3), then flush together with issue tp -> pending_cnt=0, no busy bits, a later wb ra writes data and pending_cnt stays 0.
REQ-036 SHALL cover reset mid-operation: rstN=0 with 2 busy registers and wb_en=1 -> all registers 0, pending_cnt=0, stall=0 on the next cycle.
